// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves a decode-stage branch or jump one cycle after it is presented.
// The unit compares rs1/rs2 with the funct3 condition, picks the word-address
// target, and flags a mispredict when the target differs from the PC that
// fetch already issued. A table of 2-bit saturating counters (BHT) is trained
// by conditional branches and read combinationally by fetch.
//
// Optional feature macro: BRU_STATS_EN
//   defined   : br_count / miss_count are live 32-bit wrapping counters
//   undefined : br_count / miss_count are tied to 0 and no counter flops exist
//
// Parameters
//   PC_W       word-address PC width
//   XLEN       register / immediate width (must be at least PC_W+2)
//   BHT_IDX_W  BHT index width, table depth 2^BHT_IDX_W (must be below PC_W)
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   in_valid       branch/jump slot valid
//   flush          kill the current slot
//   pc             PC of the instruction being resolved
//   pc_predicted   PC fetched after it
//   imm            immediate
//   reg_data1/2    rs1 / rs2 values
//   jump_code      11 JALR, 10 JAL, 01 conditional branch, 00 none
//   branch_code    funct3 compare select
//   cannot_predict suppress the mispredict check
//   pred_pc        fetch-side BHT lookup address
//   pred_taken     BHT prediction for pred_pc (combinational)
//   out_valid      registered slot-accepted strobe
//   nextpc         registered resolved next PC
//   fail_predict   registered mispredict, redirect fetch to nextpc
//   br_count       accepted conditional branches
//   miss_count     accepted mispredicts
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int PC_W      = 13,
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] pc_predicted,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] reg_data1,
    input  logic [XLEN-1:0] reg_data2,
    input  logic [1:0]      jump_code,
    input  logic [2:0]      branch_code,
    input  logic            cannot_predict,
    input  logic [PC_W-1:0] pred_pc,
    output logic            pred_taken,
    output logic            out_valid,
    output logic [PC_W-1:0] nextpc,
    output logic            fail_predict,
    output logic [31:0]     br_count,
    output logic [31:0]     miss_count
);

    localparam int BHT_DEPTH = 1 << BHT_IDX_W;

    localparam logic [1:0] JC_NONE   = 2'b00;
    localparam logic [1:0] JC_BRANCH = 2'b01;
    localparam logic [1:0] JC_JAL    = 2'b10;
    localparam logic [1:0] JC_JALR   = 2'b11;

    localparam logic [2:0] BC_EQ  = 3'b000;
    localparam logic [2:0] BC_NE  = 3'b001;
    localparam logic [2:0] BC_LT  = 3'b100;
    localparam logic [2:0] BC_GE  = 3'b101;
    localparam logic [2:0] BC_LTU = 3'b110;
    localparam logic [2:0] BC_GEU = 3'b111;

    logic                 cond_flag;
    logic                 is_eq;
    logic                 is_lt;
    logic                 is_ltu;
    logic [PC_W-1:0]      reg_off;
    logic [PC_W-1:0]      imm_off;
    logic [PC_W-1:0]      target;
    logic                 accept;
    logic                 mispredict;
    logic                 bht_update;
    logic [BHT_IDX_W-1:0] bht_wr_idx;
    logic [BHT_IDX_W-1:0] bht_rd_idx;
    logic [1:0]           bht_cur;
    logic [1:0]           bht_nxt;
    logic [1:0]           bht [BHT_DEPTH];

    // Byte-address operands reduced to word offsets; upper bits beyond PC_W
    // fall away, which gives the silent modulo-2^PC_W wrap of the target.
    assign reg_off = reg_data1[PC_W+1:2];
    assign imm_off = imm[PC_W+1:2];

    assign is_eq  = (reg_data1 == reg_data2);
    assign is_lt  = ($signed(reg_data1) < $signed(reg_data2));
    assign is_ltu = (reg_data1 < reg_data2);

    always_comb begin
        cond_flag = 1'b0;
        case (branch_code)
            BC_EQ:   cond_flag = is_eq;
            BC_NE:   cond_flag = ~is_eq;
            BC_LT:   cond_flag = is_lt;
            BC_GE:   cond_flag = ~is_lt;
            BC_LTU:  cond_flag = is_ltu;
            BC_GEU:  cond_flag = ~is_ltu;
            default: cond_flag = 1'b0;
        endcase
    end

    always_comb begin
        target = pc + PC_W'(1);
        case (jump_code)
            JC_JALR:   target = reg_off + imm_off;
            JC_JAL:    target = pc + imm_off;
            JC_BRANCH: target = cond_flag ? (pc + imm_off) : (pc + PC_W'(1));
            JC_NONE:   target = pc + PC_W'(1);
            default:   target = pc + PC_W'(1);
        endcase
    end

    assign accept     = in_valid & ~flush & ~rst;
    assign mispredict = accept & ~cannot_predict & (target != pc_predicted);
    assign bht_update = accept & (jump_code == JC_BRANCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            nextpc       <= '0;
            fail_predict <= 1'b0;
        end else begin
            out_valid    <= accept;
            fail_predict <= mispredict;
            if (accept) begin
                nextpc <= target;
            end
        end
    end

    // BHT: saturating 2-bit counters. The read port sees the registered
    // array, so a same-cycle write to the same entry returns the old value.
    assign bht_wr_idx = pc[BHT_IDX_W-1:0];
    assign bht_rd_idx = pred_pc[BHT_IDX_W-1:0];
    assign bht_cur    = bht[bht_wr_idx];
    assign pred_taken = bht[bht_rd_idx][1];

    always_comb begin
        bht_nxt = bht_cur;
        if (cond_flag) begin
            if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'd1;
        end else begin
            if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (bht_update) begin
            bht[bht_wr_idx] <= bht_nxt;
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (bht_update) br_count   <= br_count + 32'd1;
            if (mispredict) miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign br_count   = 32'd0;
    assign miss_count = 32'd0;
`endif

    // Immediate bits outside the word-offset field and the pred_pc bits above
    // the BHT index carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{imm[XLEN-1:PC_W+2], imm[1:0], pred_pc[PC_W-1:BHT_IDX_W]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed plus short random stimulus for branch_resolve_unit. Expected
// results come from a behavioural model; resolved slots are queued when
// driven and popped when the unit reports out_valid.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic [12:0] pc;
    logic [12:0] pc_predicted;
    logic [31:0] imm;
    logic [31:0] reg_data1;
    logic [31:0] reg_data2;
    logic [1:0]  jump_code;
    logic [2:0]  branch_code;
    logic        cannot_predict;
    logic [12:0] pred_pc;
    logic        pred_taken;
    logic        out_valid;
    logic [12:0] nextpc;
    logic        fail_predict;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    branch_resolve_unit #(.PC_W(13), .XLEN(32), .BHT_IDX_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .pc(pc),
        .pc_predicted(pc_predicted), .imm(imm), .reg_data1(reg_data1),
        .reg_data2(reg_data2), .jump_code(jump_code), .branch_code(branch_code),
        .cannot_predict(cannot_predict), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .out_valid(out_valid), .nextpc(nextpc), .fail_predict(fail_predict),
        .br_count(br_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] tgt;
        logic        fail;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  m_bht [64];
    logic [12:0] m_nextpc;
    logic [31:0] m_br;
    logic [31:0] m_miss;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_flag(input logic [2:0] bc, input logic [31:0] a, input logic [31:0] b);
        case (bc)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [12:0] m_target(input logic [1:0] jc, input logic fl,
                                             input logic [12:0] p, input logic [31:0] im,
                                             input logic [31:0] r1);
        logic [12:0] io;
        logic [12:0] ro;
        io = im[14:2];
        ro = r1[14:2];
        case (jc)
            2'b11:   return ro + io;
            2'b10:   return p + io;
            2'b01:   return fl ? (p + io) : (p + 13'd1);
            default: return p + 13'd1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_nextpc = '0;
        m_br     = '0;
        m_miss   = '0;
        sb.delete();
    endtask

    // One clock of stimulus: drive, check the combinational BHT read against
    // the pre-edge model, clock, then check registered outputs.
    task automatic step(input logic v, input logic fl, input logic rs, input logic cp,
                        input logic [1:0] jc, input logic [2:0] bc,
                        input logic [12:0] p, input logic [12:0] pp,
                        input logic [31:0] im, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [12:0] ppc);
        logic        flag;
        logic        acc;
        logic        fail;
        logic [12:0] tgt;
        exp_t        e;
        in_valid = v; flush = fl; rst = rs; cannot_predict = cp;
        jump_code = jc; branch_code = bc; pc = p; pc_predicted = pp;
        imm = im; reg_data1 = r1; reg_data2 = r2; pred_pc = ppc;
        #1;
        check("pred_taken", {31'd0, pred_taken}, {31'd0, m_bht[ppc[5:0]][1]});
        flag = m_flag(bc, r1, r2);
        tgt  = m_target(jc, flag, p, im, r1);
        acc  = v & ~fl & ~rs;
        fail = acc & ~cp & (tgt != pp);
        if (acc) sb.push_back('{tgt: tgt, fail: fail});
        @(posedge clk);
        #1;
        if (rs) begin
            model_reset();
        end else if (acc) begin
            m_nextpc = tgt;
            if (jc == 2'b01) begin
                m_br = m_br + 32'd1;
                if (flag && m_bht[p[5:0]] != 2'b11) m_bht[p[5:0]] = m_bht[p[5:0]] + 2'd1;
                if (!flag && m_bht[p[5:0]] != 2'b00) m_bht[p[5:0]] = m_bht[p[5:0]] - 2'd1;
            end
            if (fail) m_miss = m_miss + 32'd1;
        end
        check("out_valid", {31'd0, out_valid}, {31'd0, acc});
        if (out_valid === 1'b1) begin
            check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("nextpc", {19'd0, nextpc}, {19'd0, e.tgt});
                check("fail_predict", {31'd0, fail_predict}, {31'd0, e.fail});
            end
        end else begin
            if (sb.size() != 0) void'(sb.pop_front());
            check("fail_idle", {31'd0, fail_predict}, 32'd0);
        end
        check("nextpc_reg", {19'd0, nextpc}, {19'd0, m_nextpc});
`ifdef BRU_STATS_EN
        check("br_count", br_count, m_br);
        check("miss_count", miss_count, m_miss);
`else
        check("br_count", br_count, 32'd0);
        check("miss_count", miss_count, 32'd0);
`endif
    endtask

    task automatic scan_bht();
        in_valid = 1'b0; rst = 1'b0; flush = 1'b0;
        for (int i = 0; i < 64; i++) begin
            pred_pc = 13'(i);
            #1;
            check("bht_scan", {31'd0, pred_taken}, {31'd0, m_bht[i][1]});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; pc = '0; pc_predicted = '0;
        imm = '0; reg_data1 = '0; reg_data2 = '0; jump_code = '0; branch_code = '0;
        cannot_predict = 1'b0; pred_pc = '0;
        model_reset();
        @(posedge clk);
        #1;
        step(0, 0, 1, 0, 2'b00, 3'b000, 13'h0000, 13'h0000, 32'h0, 32'h0, 32'h0, 13'h0000);
        scan_bht();

        // taken BEQ, mispredicted
        step(1, 0, 0, 0, 2'b01, 3'b000, 13'h0100, 13'h0101, 32'h10, 32'd5, 32'd5, 13'h0100);
        // JALR predicted correctly, then with cannot_predict
        step(1, 0, 0, 0, 2'b11, 3'b000, 13'h0300, 13'h0402, 32'h8, 32'h1000, 32'h0, 13'h0000);
        step(1, 0, 0, 1, 2'b11, 3'b000, 13'h0300, 13'h0000, 32'h8, 32'h1000, 32'h0, 13'h0000);
        // JAL
        step(1, 0, 0, 0, 2'b10, 3'b000, 13'h0200, 13'h0210, 32'h40, 32'h0, 32'h0, 13'h0000);
        // signed vs unsigned compares
        step(1, 0, 0, 0, 2'b01, 3'b100, 13'h0500, 13'h0501, 32'h20, 32'hFFFFFFFF, 32'd1, 13'h0000);
        step(1, 0, 0, 0, 2'b01, 3'b110, 13'h0500, 13'h0501, 32'h20, 32'hFFFFFFFF, 32'd1, 13'h0000);
        step(1, 0, 0, 0, 2'b01, 3'b101, 13'h0600, 13'h0608, 32'h20, 32'd3, 32'hFFFFFFFF, 13'h0000);
        step(1, 0, 0, 0, 2'b01, 3'b111, 13'h0600, 13'h0601, 32'h20, 32'd3, 32'hFFFFFFFF, 13'h0000);
        step(1, 0, 0, 0, 2'b01, 3'b001, 13'h0700, 13'h0701, 32'h20, 32'd3, 32'd4, 13'h0000);
        step(1, 0, 0, 0, 2'b01, 3'b010, 13'h0700, 13'h0708, 32'h20, 32'd3, 32'd3, 13'h0000);

        // BHT saturation at 0x40: three taken, then four not-taken
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 2'b01, 3'b000, 13'h0040, 13'h0041, 32'h10, 32'd7, 32'd7, 13'h0040);
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 2'b01, 3'b001, 13'h0040, 13'h0041, 32'h10, 32'd7, 32'd7, 13'h0040);
        step(0, 0, 0, 0, 2'b00, 3'b000, 13'h0000, 13'h0000, 32'h0, 32'h0, 32'h0, 13'h0040);

        // wrap-around: pc+1 at the top, and a negative JAL offset
        step(1, 0, 0, 0, 2'b00, 3'b000, 13'h1FFF, 13'h0000, 32'h0, 32'h0, 32'h0, 13'h0000);
        step(1, 0, 0, 0, 2'b10, 3'b000, 13'h0002, 13'h0000, 32'hFFFFFFF0, 32'h0, 32'h0, 13'h0000);
        // flushed taken branch at 0x40 must leave BHT, counters and nextpc alone
        step(1, 1, 0, 0, 2'b01, 3'b000, 13'h0040, 13'h0000, 32'h10, 32'd1, 32'd1, 13'h0040);
        step(0, 0, 0, 0, 2'b00, 3'b000, 13'h0000, 13'h0000, 32'h0, 32'h0, 32'h0, 13'h0040);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), 1'b0,
                 ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 13'($urandom()), 13'($urandom()), $urandom(), a, b, 13'($urandom()));
        end

        // reset mid-stream with a slot in flight and one presented with rst
        step(1, 0, 0, 0, 2'b01, 3'b000, 13'h0040, 13'h0000, 32'h10, 32'd2, 32'd2, 13'h0040);
        step(1, 0, 1, 0, 2'b01, 3'b000, 13'h0040, 13'h0000, 32'h10, 32'd2, 32'd2, 13'h0040);
        scan_bht();
        // one taken branch from 01 must reach 10, proving reset to 01 not 00
        step(1, 0, 0, 0, 2'b01, 3'b000, 13'h0040, 13'h0044, 32'h10, 32'd9, 32'd9, 13'h0040);
        step(0, 0, 0, 0, 2'b00, 3'b000, 13'h0000, 13'h0000, 32'h0, 32'h0, 32'h0, 13'h0040);
        step(1, 0, 0, 0, 2'b01, 3'b000, 13'h0013, 13'h0017, 32'h10, 32'd9, 32'd9, 13'h0013);
        step(0, 0, 0, 0, 2'b00, 3'b000, 13'h0000, 13'h0000, 32'h0, 32'h0, 32'h0, 13'h0013);

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
